// File: rtl/sa_tile_ctrl.sv
// Sequencing controller for the 16x16 systolic-array tile: weight load, activation streaming,
// and result tracking. Optional stall counter enabled by defining SA_CTRL_PERF_EN.
module sa_tile_ctrl #(
    parameter int unsigned N_VEC_W  = 10,
    parameter int unsigned PIPE_LAT = 32,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_VEC_W-1:0] n_vec,
    input  logic               transpose_cfg,
    input  logic               act_avail,
    output logic               busy,
    output logic               done,
    output logic               w_rd_en,
    output logic [3:0]         w_rd_addr,
    output logic               load_w,
    output logic               transpose_en,
    output logic               act_rd_en,
    output logic [N_VEC_W-1:0] act_rd_addr,
    output logic               act_zero,
    output logic               out_valid,
    output logic [N_VEC_W-1:0] out_idx
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int unsigned TokDepth = RD_LAT + PIPE_LAT;

    typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         w_cnt_q, w_cnt_d;
    logic [N_VEC_W-1:0] act_addr_q, act_addr_d;
    logic [N_VEC_W-1:0] n_vec_q, n_vec_d;
    logic               transpose_q, transpose_d;
    logic [RD_LAT-1:0]  w_dly_q, w_dly_d;
    logic [RD_LAT-1:0]  a_dly_q, a_dly_d;
    logic [TokDepth-1:0] tok_v_q, tok_v_d;
    logic [N_VEC_W-1:0] tok_idx_q [TokDepth];
    logic [N_VEC_W-1:0] tok_idx_d [TokDepth];
    logic [N_VEC_W:0]   rd_next;
    logic               stall;

    // Extra bit so the last-read compare cannot wrap at the maximum count.
    assign rd_next = {1'b0, act_addr_q} + {{N_VEC_W{1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        w_cnt_d     = w_cnt_q;
        act_addr_d  = act_addr_q;
        n_vec_d     = n_vec_q;
        transpose_d = transpose_q;
        busy        = 1'b0;
        done        = 1'b0;
        w_rd_en     = 1'b0;
        act_rd_en   = 1'b0;
        stall       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoadW;
                    w_cnt_d     = 4'd0;
                    act_addr_d  = '0;
                    n_vec_d     = n_vec;
                    transpose_d = transpose_cfg;
                end
            end
            StLoadW: begin
                busy    = 1'b1;
                w_rd_en = 1'b1;
                w_cnt_d = w_cnt_q + 4'd1;
                if (w_cnt_q == 4'hF) begin
                    state_d = (n_vec_q == '0) ? StDrain : StStream;
                end
            end
            StStream: begin
                busy = 1'b1;
                if (act_avail) begin
                    act_rd_en  = 1'b1;
                    act_addr_d = rd_next[N_VEC_W-1:0];
                    if (rd_next == {1'b0, n_vec_q}) begin
                        state_d = StDrain;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            StDrain: begin
                busy = 1'b1;
                // Leave once only the output stage can still hold a token, so done
                // lands in the cycle right after the last valid result.
                if (tok_v_q[TokDepth-2:0] == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        w_dly_d      = w_dly_q;
        a_dly_d      = a_dly_q;
        tok_v_d      = tok_v_q;
        tok_idx_d    = tok_idx_q;
        w_dly_d[0]   = w_rd_en;
        a_dly_d[0]   = act_rd_en;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            w_dly_d[i] = w_dly_q[i-1];
            a_dly_d[i] = a_dly_q[i-1];
        end
        tok_v_d[0]   = act_rd_en;
        tok_idx_d[0] = act_rd_en ? act_addr_q : '0;
        for (int unsigned i = 1; i < TokDepth; i++) begin
            tok_v_d[i]   = tok_v_q[i-1];
            tok_idx_d[i] = tok_idx_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            w_cnt_q     <= 4'd0;
            act_addr_q  <= '0;
            n_vec_q     <= '0;
            transpose_q <= 1'b0;
            w_dly_q     <= '0;
            a_dly_q     <= '0;
            tok_v_q     <= '0;
            for (int unsigned i = 0; i < TokDepth; i++) begin
                tok_idx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            w_cnt_q     <= w_cnt_d;
            act_addr_q  <= act_addr_d;
            n_vec_q     <= n_vec_d;
            transpose_q <= transpose_d;
            w_dly_q     <= w_dly_d;
            a_dly_q     <= a_dly_d;
            tok_v_q     <= tok_v_d;
            tok_idx_q   <= tok_idx_d;
        end
    end

    assign w_rd_addr    = w_cnt_q;
    assign load_w       = w_dly_q[RD_LAT-1];
    assign transpose_en = transpose_q;
    assign act_rd_addr  = act_addr_q;
    assign act_zero     = ~a_dly_q[RD_LAT-1];
    assign out_valid    = tok_v_q[TokDepth-1];
    assign out_idx      = tok_idx_q[TokDepth-1];

`ifdef SA_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == StIdle && start) begin
            stall_cnt_d = 16'd0;
        end else if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Directed self-checking bench for sa_tile_ctrl; cycle 0 is the cycle start is driven,
// cycle k is the k-th cycle after the accepting edge.
module tb_sa_tile_ctrl;

    localparam int unsigned NW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NW-1:0] n_vec;
    logic          transpose_cfg;
    logic          act_avail;
    logic          busy, done, w_rd_en, load_w, transpose_en, act_rd_en, act_zero, out_valid;
    logic [3:0]    w_rd_addr;
    logic [NW-1:0] act_rd_addr, out_idx;
`ifdef SA_CTRL_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic last_t  = 1'b0;

    always #5 clk = ~clk;

    sa_tile_ctrl #(.N_VEC_W(NW), .PIPE_LAT(32), .RD_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .n_vec         (n_vec),
        .transpose_cfg (transpose_cfg),
        .act_avail     (act_avail),
        .busy          (busy),
        .done          (done),
        .w_rd_en       (w_rd_en),
        .w_rd_addr     (w_rd_addr),
        .load_w        (load_w),
        .transpose_en  (transpose_en),
        .act_rd_en     (act_rd_en),
        .act_rd_addr   (act_rd_addr),
        .act_zero      (act_zero),
        .out_valid     (out_valid),
        .out_idx       (out_idx)
`ifdef SA_CTRL_PERF_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] bits(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Advance to the next cycle and sample 3 time units after the rising edge.
    task automatic tick(input logic avail);
        @(posedge clk);
        #2;
        start     = 1'b0;
        act_avail = avail;
        cyc++;
        #1;
    endtask

    task automatic txn(input int n, input logic [63:0] avail_m, input logic [63:0] rd_m,
                       input logic [63:0] out_m, input int done_c, input logic tcfg,
                       input logic poke30, input int exp_stall);
        int   rd_cnt  = 0;
        int   out_cnt = 0;
        logic prev_rd = 1'b0;
        cyc           = 0;
        start         = 1'b1;
        n_vec         = NW'(n);
        transpose_cfg = tcfg;
        #1;
        chk1("c0_busy", busy, 1'b0);
        chk1("c0_act_zero", act_zero, 1'b1);
        chk1("c0_transpose_hold", transpose_en, last_t);
        for (int c = 1; c <= done_c + 1; c++) begin
            tick(avail_m[c]);
            if (c == 5) transpose_cfg = ~tcfg;
            if (poke30 && c == 30) start = 1'b1;
            chk1("busy", busy, c <= done_c);
            chk1("done", done, c == done_c);
            chk1("w_rd_en", w_rd_en, c <= 16);
            if (c <= 16) chkv("w_rd_addr", 32'(w_rd_addr), c - 1);
            chk1("load_w", load_w, c >= 2 && c <= 17);
            chk1("act_rd_en", act_rd_en, rd_m[c]);
            if (rd_m[c]) begin
                chkv("act_rd_addr", 32'(act_rd_addr), rd_cnt);
                rd_cnt++;
            end
            chk1("act_zero", act_zero, ~prev_rd);
            prev_rd = rd_m[c];
            chk1("out_valid", out_valid, out_m[c]);
            if (out_m[c]) begin
                chkv("out_idx", 32'(out_idx), out_cnt);
                out_cnt++;
            end
            chk1("transpose_en", transpose_en, tcfg);
        end
`ifdef SA_CTRL_PERF_EN
        chkv("stall_cnt", 32'(stall_cnt), exp_stall);
`else
        if (exp_stall < 0) $display("[TB] unexpected stall expectation");
`endif
        last_t = tcfg;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        n_vec         = '0;
        transpose_cfg = 1'b0;
        act_avail     = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_act_zero", act_zero, 1'b1);
        chk1("rst_w_rd_en", w_rd_en, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1);

        // Basic: 4 vectors, no stalls.
        txn(4, ~64'd0, bits(17, 20), bits(50, 53), 54, 1'b0, 1'b0, 0);
        // Stall in cycle 18, transpose latched 1, stray start in cycle 30; begins right after done.
        txn(3, ~bits(18, 18), bits(17, 17) | bits(19, 20), bits(50, 50) | bits(52, 53), 54,
            1'b1, 1'b1, 1);
        // Zero vectors: weight load only, pipe already empty.
        txn(0, ~64'd0, 64'd0, 64'd0, 18, 1'b0, 1'b0, 0);

        // Reset in cycle 25 of an 8-vector run.
        cyc           = 0;
        start         = 1'b1;
        n_vec         = NW'(8);
        transpose_cfg = 1'b1;
        for (int c = 1; c <= 25; c++) tick(1'b1);
        chk1("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_act_zero", act_zero, 1'b1);
        chk1("mid_rst_w_rd_en", w_rd_en, 1'b0);
        chk1("mid_rst_act_rd_en", act_rd_en, 1'b0);
        chk1("mid_rst_load_w", load_w, 1'b0);
        chk1("mid_rst_transpose_en", transpose_en, 1'b0);
        chkv("mid_rst_act_rd_addr", 32'(act_rd_addr), 0);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick(1'b1);
            chk1("post_rst_out_valid", out_valid, 1'b0);
            chk1("post_rst_done", done, 1'b0);
            chk1("post_rst_busy", busy, 1'b0);
        end
        last_t = 1'b0;
        txn(4, ~64'd0, bits(17, 20), bits(50, 53), 54, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_tile_ctrl.md
Name: sa_tile_ctrl

Overview:
Sequencing controller for the 16x16 systolic-array tile: weight buffer, skew regs, array, deskew regs.
One transaction per start pulse:
- Loads 16 weight rows from the weight buffer.
- Streams N activation vectors from the activation buffer, inserting zero bubbles whenever the source stalls.
- Tracks each vector through the fixed array pipeline and flags valid output vectors at the deskew output.
Sits between the layer scheduler (start/done) and the SA tile plus its operand buffers.

Parameters:
N_VEC_W, 10, width of vector-count and activation-address fields.
PIPE_LAT, 32, cycles from activation vector at tile act_in to matching result at tile psum_out.
RD_LAT, 1, read latency of weight and activation buffers (fixed at 1 for this version).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
start  in  1  one-cycle transaction request; sampled only in IDLE.
n_vec  in  N_VEC_W  number of activation vectors; latched on accepted start.
transpose_cfg  in  1  transpose mode; latched on accepted start.
act_avail  in  1  activation buffer holds the next vector.
busy  out  1  transaction in progress.
done  out  1  one-cycle completion pulse.
w_rd_en  out  1  weight buffer read enable.
w_rd_addr  out  4  weight row address.
load_w  out  1  to tile; high in the cycle weight_in carries valid row data.
transpose_en  out  1  to tile; latched transpose_cfg.
act_rd_en  out  1  activation buffer read enable.
act_rd_addr  out  N_VEC_W  activation vector index.
act_zero  out  1  forces tile act_in to zero (bubble or idle).
out_valid  out  1  tile psum_out holds a real result vector.
out_idx  out  N_VEC_W  index of the vector flagged by out_valid.

Behaviour:
- Reset: all outputs 0, act_zero = 1, FSM in IDLE, token pipe cleared, counters 0. Reset mid-transaction aborts immediately; no done pulse.
- Cycle k = k-th rising edge after the edge that accepted start.
- FSM states:
  - IDLE: start accepted; latch n_vec and transpose_cfg; busy = 1 from cycle 1. Start while busy is ignored.
  - LOAD_W: cycles 1..16. w_rd_en = 1, w_rd_addr = 0..15 ascending. load_w = w_rd_en delayed by RD_LAT, i.e. cycles 2..17. Then go to STREAM, or to DRAIN if n_vec == 0.
  - STREAM:
    - Each cycle with act_avail = 1: act_rd_en = 1 with the current act_rd_addr, then increment the address.
    - Each cycle with act_avail = 0: no read; a bubble enters the pipe.
    - Leaves to DRAIN in the cycle after the n_vec-th read.
  - DRAIN: wait until the token pipe is empty, then go to DONE.
  - DONE: done = 1 for one cycle, busy = 1 in that cycle, return to IDLE.
- Activation data path:
  - Data reaches tile act_in RD_LAT cycles after act_rd_en.
  - act_zero = NOT (act_rd_en delayed RD_LAT). This gives zeros during load, bubbles and drain.
- Token pipe: shift register of depth RD_LAT + PIPE_LAT carrying a valid bit plus vector index. out_valid/out_idx are its output. Bubbles carry valid = 0.
- Result count: out_valid asserts exactly n_vec times per transaction, with out_idx ascending 0..n_vec-1. Gaps appear exactly where bubbles were inserted.
- transpose_en: held constant from cycle 1 through DONE; holds its value in IDLE until the next accepted start.
- act_rd_addr: resets to 0 on each accepted start. Maximum count 2^N_VEC_W - 1; no wrap within a transaction.
- done with out_valid: done is never coincident with out_valid. It comes in the cycle after the last valid output.

Optional Feature:
Macro SA_CTRL_PERF_EN.
- Defined: adds output stall_cnt[15:0], counting STREAM cycles with act_avail = 0. Saturates at 16'hFFFF, cleared on accepted start, holds after done, reset to 0.
- Not defined: stall_cnt port and counter are absent; all other behaviour identical.

Test Plan:
- Basic transaction: n_vec = 4, act_avail = 1, start at cycle 0 ->
  - w_rd_en cycles 1..16 (addr 0..15); load_w cycles 2..17.
  - act_rd_en cycles 17..20; act_zero = 0 cycles 18..21.
  - out_valid cycles 50..53 with out_idx 0..3.
  - done cycle 54; busy cycles 1..54.
- Stall: n_vec = 3, act_avail low only in cycle 18 -> reads in cycles 17, 19, 20; out_valid cycles 50, 52, 53 (idx 0, 1, 2); done cycle 54. With SA_CTRL_PERF_EN, stall_cnt = 1.
- Zero vectors: n_vec = 0 -> weight load runs normally; no act_rd_en; no out_valid; done pulses after the pipe drains; busy then drops.
- Start while busy: second start pulse in cycle 30 -> ignored; exactly one done. A start in the cycle after done is accepted.
- Reset mid-operation: rst asserted in cycle 25 of an n_vec = 8 run -> all outputs 0 and act_zero = 1 immediately. No out_valid or done afterwards. A subsequent start runs a full, correct transaction.
- Transpose: transpose_cfg = 1 at start, toggled to 0 during the run -> transpose_en = 1 through DONE and after it, until the next start latches 0.
